turn_signal_arbiter: RTL and testbench
======================================

# turn_signal_arbiter

Request arbiter and burst scheduler that sits between the driver switches (Left, Right, Hazard) and the turn-light pattern sequencer. It debounces the switches and resolves them to a single command: hazard outranks turn, and Left+Right together counts as hazard. It issues one sequence burst at a time over a valid/ready handshake, inserts an inter-burst gap, and locks out a turn request that has run for too many consecutive bursts.

## Interface
- DEB_CYCLES, 2: consecutive identical samples needed to change a filtered input (≥1).
- GAP_CYCLES, 1: idle cycles between bursts; 0 is treated as 1.
- MAX_BURSTS, 8: consecutive bursts of one turn code before lockout; 0 means unlimited. Never applies to hazard.
- slow_clk  in  1  block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- left_in / right_in / hazard_in  in  1 each  raw switch levels.
- cmd_ready  in  1  sequencer accepts a command.
- seq_done  in  1  one-cycle pulse from the sequencer at the end of a burst.
- cmd_valid  out  1  command offered.
- cmd_code  out  2  00 none, 01 left, 10 right, 11 hazard.
- burst_cnt  out  4  completed bursts of the current code, saturating at 15.
- lockout  out  1  turn request suppressed.
- state_o  out  2  00 IDLE, 01 ISSUE, 10 RUN, 11 GAP.

## Operation
- **Reset values:** all outputs 0, state IDLE, filtered inputs 0, debounce counters 0, locked_code 00.
- **Debounce (per input):**
  - A counter increments while the raw input differs from the filtered value.
  - It clears when the raw input matches the filtered value.
  - On reaching DEB_CYCLES, the filtered value takes the raw value and the counter clears.
- **Request decode** (combinational, on filtered inputs):
  - hazard, or left&right → 11.
  - left only → 01.
  - right only → 10.
  - none → 00.
  - When lockout=1 and the request equals locked_code, the request is treated as 00.
- **Lockout clear:** lockout clears when the decoded request (before masking) differs from locked_code.
- **IDLE:** on request ≠00, latch cmd_code = request and clear burst_cnt, then go to ISSUE. On entry to IDLE, cmd_code and burst_cnt clear.
- **ISSUE:**
  - cmd_valid=1, with cmd_code held stable until accepted.
  - No retraction: if the request drops or changes, the command is still held.
  - On cmd_valid&cmd_ready, go to RUN; cmd_valid is 0 from the next cycle.
- **RUN:**
  - Wait for seq_done, then burst_cnt+1 (saturating).
  - If cmd_code≠11, MAX_BURSTS≠0 and the new count == MAX_BURSTS: set lockout, set locked_code=cmd_code, go to IDLE.
  - Otherwise go to GAP.
  - No preemption: a hazard arriving mid-burst waits for seq_done.
- **GAP:** wait max(GAP_CYCLES,1) cycles, then:
  - request == cmd_code → ISSUE (burst_cnt kept).
  - request ≠00 and different → ISSUE with the new code, burst_cnt=0.
  - request 00 → IDLE.
- **seq_done handling:** ignored outside RUN. cmd_ready is ignored outside ISSUE.
- **Reset mid-operation:** everything returns to reset values at the reset edge; cmd_valid drops in the same cycle reset is sampled. An in-flight burst is abandoned.

## Timing
- A raw input change stable before edge 1 updates the filtered value at edge DEB_CYCLES.
- cmd_valid is registered high at edge DEB_CYCLES+1 (edge 3 by default).
- Accept latency: ISSUE→RUN on the edge where valid&ready is sampled. cmd_ready tied high gives a 1-cycle valid pulse.
- From seq_done, GAP begins on the next edge. The next cmd_valid rises GAP_CYCLES+1 edges after the seq_done edge (default 2).
- Lockout is set on the seq_done edge of the final burst. It clears one edge after the filtered request changes.
- Simultaneous: left and right becoming filtered-high on the same edge → 11, never 01 or 10.

## Test plan
- **Defaults, single left burst:** left_in=1 with ready=1 → cmd_valid=1 and cmd_code=01 after edge 3. Then seq_done 4 cycles after accept with left released → GAP, then IDLE; cmd_code=00, burst_cnt=0.
- **Glitch rejection:** left_in high for 1 cycle only → cmd_valid never asserts, filtered value stays 0.
- **Lockout, MAX_BURSTS=3:** left held, ready=1, seq_done 4 cycles after each accept → exactly three 01 commands, lockout=1, no fourth. Release left → lockout=0 DEB_CYCLES+1 edges later. Reassert left → a fresh 01 command with burst_cnt=0.
- **Hazard exemption:** hazard held for 20 bursts with MAX_BURSTS=3 → continuous 11 commands, lockout stays 0, burst_cnt saturates at 15.
- **Priority and no preemption:** left in RUN, hazard rises mid-burst → no new command until seq_done. After the gap, cmd_code=11 and burst_cnt restarts at 0. Left+right together also gives 11.
- **Handshake hold and reset:** ready=0 for 5 cycles → cmd_valid and cmd_code stable throughout, even if left is released. Reset asserted in RUN → all outputs 0 and state_o=00 on the next edge.

Source files
------------

// File: rtl/turn_signal_arbiter_if.sv
// turn_signal_arbiter_if: command handshake between the arbiter (master) and the pattern sequencer (slave)
// cmd_valid/cmd_code: command offered by the arbiter; cmd_ready: sequencer accepts; seq_done: end-of-burst pulse
interface turn_signal_arbiter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       seq_done;
  modport master (output cmd_valid, cmd_code, input cmd_ready, seq_done);
  modport slave (input cmd_valid, cmd_code, output cmd_ready, seq_done);
endinterface

// File: rtl/turn_signal_arbiter.sv
// turn_signal_arbiter: debounces turn/hazard switches and schedules one sequencer burst at a time
// slow_clk/reset: clock and synchronous active-high reset
// left_in/right_in/hazard_in: raw switch levels
// bus: cmd_valid/cmd_code out, cmd_ready/seq_done in
// burst_cnt: completed bursts of current code (saturating); lockout: turn request suppressed
// state_o: 00 IDLE, 01 ISSUE, 10 RUN, 11 GAP
module turn_signal_arbiter #(
  parameter int DEB_CYCLES = 2,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_BURSTS = 8
) (
  input  logic                         slow_clk,
  input  logic                         reset,
  input  logic                         left_in,
  input  logic                         right_in,
  input  logic                         hazard_in,
  turn_signal_arbiter_if.master        bus,
  output logic [3:0]                   burst_cnt,
  output logic                         lockout,
  output logic [1:0]                   state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RUN = 2'b10, GAP = 2'b11} state_t;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GL = GAP_CYCLES < 1 ? 1 : GAP_CYCLES;
  localparam int GW = $clog2(GL + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
  // burst_cnt saturates at 15, so a larger limit could never be reached
  localparam bit LOCK_EN = MAX_BURSTS > 0 && MAX_BURSTS < 16;
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURSTS);
  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [1:0]           code_q, code_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 lockout_q, lockout_d;
  logic [1:0]           locked_q, locked_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [2:0]           filt_q, filt_d;
  logic [2:0][DW-1:0]   deb_q, deb_d;
  logic [2:0]           raw;
  logic [1:0]           req_raw, req;
  logic [3:0]           new_cnt;
  logic                 lock_hit;
  assign raw      = {hazard_in, right_in, left_in};
  assign req_raw  = filt_q[2] || (filt_q[0] && filt_q[1]) ? 2'b11 : {filt_q[1], filt_q[0]};
  assign req      = lockout_q && req_raw == locked_q ? 2'b00 : req_raw;
  assign new_cnt  = cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1;
  assign lock_hit = LOCK_EN && code_q != 2'b11 && new_cnt == MAX_CNT;
  always_comb begin
    filt_d = filt_q;
    deb_d  = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = raw[i] == filt_q[i] ? '0 : deb_q[i] + DW'(1);
      if (deb_d[i] == DEB_MAX) begin
        filt_d[i] = raw[i];
        deb_d[i]  = '0;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    locked_d  = locked_q;
    lockout_d = lockout_q && req_raw == locked_q;
    case (state_q)
      IDLE: if (req != 2'b00) begin
        state_d = ISSUE;
        valid_d = 1'b1;
        code_d  = req;
        cnt_d   = '0;
      end
      ISSUE: if (bus.cmd_ready) begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: if (bus.seq_done) begin
        if (lock_hit) begin
          state_d   = IDLE;
          lockout_d = 1'b1;
          locked_d  = code_q;
          code_d    = '0;
          cnt_d     = '0;
        end else begin
          state_d = GAP;
          cnt_d   = new_cnt;
          gap_d   = GW'(GL);
        end
      end
      // the counter is loaded on the seq_done edge and the decision is taken once it has run down to zero
      GAP: if (gap_q != '0) gap_d = gap_q - GW'(1);
      else if (req == 2'b00) begin
        state_d = IDLE;
        code_d  = '0;
        cnt_d   = '0;
      end else begin
        state_d = ISSUE;
        valid_d = 1'b1;
        code_d  = req;
        cnt_d   = req == code_q ? cnt_q : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      code_q    <= '0;
      cnt_q     <= '0;
      lockout_q <= 1'b0;
      locked_q  <= '0;
      gap_q     <= '0;
      filt_q    <= '0;
      deb_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      lockout_q <= lockout_d;
      locked_q  <= locked_d;
      gap_q     <= gap_d;
      filt_q    <= filt_d;
      deb_q     <= deb_d;
    end
  end
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_code  = code_q;
  assign burst_cnt     = cnt_q;
  assign lockout       = lockout_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_turn_signal_arbiter.sv
// tb_turn_signal_arbiter: directed checks of debounce, scheduling, lockout, priority and reset
module tb_turn_signal_arbiter;
  localparam logic [1:0] S_IDLE = 2'b00, S_ISSUE = 2'b01, S_RUN = 2'b10, S_GAP = 2'b11;
  logic       slow_clk = 1'b0;
  logic       reset, left_in, right_in, hazard_in, lockout;
  logic [3:0] burst_cnt;
  logic [1:0] state_o;
  int         checks = 0;
  int         errors = 0;
  turn_signal_arbiter_if bus ();
  turn_signal_arbiter #(.DEB_CYCLES(2), .GAP_CYCLES(1), .MAX_BURSTS(3)) dut (
    .slow_clk (slow_clk),
    .reset    (reset),
    .left_in  (left_in),
    .right_in (right_in),
    .hazard_in(hazard_in),
    .bus      (bus),
    .burst_cnt(burst_cnt),
    .lockout  (lockout),
    .state_o  (state_o)
  );
  always #5 slow_clk = ~slow_clk;
  function automatic logic [9:0] pk(input logic v, input logic [1:0] c, input logic [3:0] n,
                                    input logic l, input logic [1:0] s);
    return {v, c, n, l, s};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge slow_clk);
    #1;
  endtask
  task automatic expect_st(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {bus.cmd_valid, bus.cmd_code, burst_cnt, lockout, state_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b required=%b (valid,code,cnt,lockout,state)", tag, obs, exp);
    end
  endtask
  task automatic do_burst(input string tag, input logic [1:0] code, input logic [3:0] n);
    expect_st({tag, "_issue"}, pk(1'b1, code, n, 1'b0, S_ISSUE));
    tick(1);
    expect_st({tag, "_run"}, pk(1'b0, code, n, 1'b0, S_RUN));
    tick(3);
    bus.seq_done = 1'b1;
    tick(1);
    bus.seq_done = 1'b0;
  endtask
  initial begin
    reset = 1'b1; left_in = 1'b0; right_in = 1'b0; hazard_in = 1'b0;
    bus.cmd_ready = 1'b0; bus.seq_done = 1'b0;
    tick(2);
    expect_st("reset", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    reset = 1'b0;
    bus.cmd_ready = 1'b1; left_in = 1'b1;
    tick(2);
    expect_st("t1_debounce", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    tick(1);
    expect_st("t1_issue", pk(1'b1, 2'b01, 4'd0, 1'b0, S_ISSUE));
    left_in = 1'b0;
    tick(1);
    expect_st("t1_run", pk(1'b0, 2'b01, 4'd0, 1'b0, S_RUN));
    tick(3);
    bus.seq_done = 1'b1;
    tick(1);
    bus.seq_done = 1'b0;
    expect_st("t1_gap", pk(1'b0, 2'b01, 4'd1, 1'b0, S_GAP));
    tick(1);
    expect_st("t1_gap2", pk(1'b0, 2'b01, 4'd1, 1'b0, S_GAP));
    tick(1);
    expect_st("t1_idle", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    left_in = 1'b1;
    tick(1);
    left_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_st("glitch", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    end
    right_in = 1'b1;
    tick(3);
    right_in = 1'b0;
    do_burst("right", 2'b10, 4'd0);
    expect_st("right_gap", pk(1'b0, 2'b10, 4'd1, 1'b0, S_GAP));
    tick(2);
    expect_st("right_idle", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    left_in = 1'b1;
    tick(3);
    do_burst("lk1", 2'b01, 4'd0);
    expect_st("lk1_gap", pk(1'b0, 2'b01, 4'd1, 1'b0, S_GAP));
    tick(2);
    do_burst("lk2", 2'b01, 4'd1);
    expect_st("lk2_gap", pk(1'b0, 2'b01, 4'd2, 1'b0, S_GAP));
    tick(2);
    do_burst("lk3", 2'b01, 4'd2);
    expect_st("lk_set", pk(1'b0, 2'b00, 4'd0, 1'b1, S_IDLE));
    for (int i = 0; i < 8; i++) begin
      tick(1);
      expect_st("lk_no_fourth", pk(1'b0, 2'b00, 4'd0, 1'b1, S_IDLE));
    end
    left_in = 1'b0;
    tick(2);
    expect_st("lk_still", pk(1'b0, 2'b00, 4'd0, 1'b1, S_IDLE));
    tick(1);
    expect_st("lk_clear", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    bus.cmd_ready = 1'b0; left_in = 1'b1;
    tick(3);
    expect_st("lk_fresh", pk(1'b1, 2'b01, 4'd0, 1'b0, S_ISSUE));
    left_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_st("hold", pk(1'b1, 2'b01, 4'd0, 1'b0, S_ISSUE));
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    expect_st("hold_accept", pk(1'b0, 2'b01, 4'd0, 1'b0, S_RUN));
    reset = 1'b1;
    tick(1);
    expect_st("reset_run", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    reset = 1'b0;
    hazard_in = 1'b1;
    tick(3);
    for (int i = 0; i < 20; i++) begin
      do_burst("hz", 2'b11, 4'(i > 15 ? 15 : i));
      expect_st("hz_gap", pk(1'b0, 2'b11, 4'(i + 1 > 15 ? 15 : i + 1), 1'b0, S_GAP));
      tick(2);
    end
    expect_st("hz_sat", pk(1'b1, 2'b11, 4'd15, 1'b0, S_ISSUE));
    hazard_in = 1'b0;
    do_burst("hz_end", 2'b11, 4'd15);
    expect_st("hz_end_gap", pk(1'b0, 2'b11, 4'd15, 1'b0, S_GAP));
    tick(2);
    expect_st("hz_idle", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    left_in = 1'b1;
    tick(3);
    expect_st("pr_issue", pk(1'b1, 2'b01, 4'd0, 1'b0, S_ISSUE));
    tick(1);
    expect_st("pr_run", pk(1'b0, 2'b01, 4'd0, 1'b0, S_RUN));
    hazard_in = 1'b1;
    tick(2);
    expect_st("pr_no_preempt", pk(1'b0, 2'b01, 4'd0, 1'b0, S_RUN));
    tick(1);
    expect_st("pr_no_preempt2", pk(1'b0, 2'b01, 4'd0, 1'b0, S_RUN));
    bus.seq_done = 1'b1;
    tick(1);
    bus.seq_done = 1'b0;
    expect_st("pr_gap", pk(1'b0, 2'b01, 4'd1, 1'b0, S_GAP));
    tick(1);
    expect_st("pr_gap2", pk(1'b0, 2'b01, 4'd1, 1'b0, S_GAP));
    tick(1);
    expect_st("pr_hazard", pk(1'b1, 2'b11, 4'd0, 1'b0, S_ISSUE));
    left_in = 1'b0; hazard_in = 1'b0;
    do_burst("pr_end", 2'b11, 4'd0);
    expect_st("pr_end_gap", pk(1'b0, 2'b11, 4'd1, 1'b0, S_GAP));
    tick(2);
    expect_st("pr_idle", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    bus.cmd_ready = 1'b0; left_in = 1'b1; right_in = 1'b1;
    tick(2);
    expect_st("lr_debounce", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    tick(1);
    expect_st("lr_hazard", pk(1'b1, 2'b11, 4'd0, 1'b0, S_ISSUE));
    left_in = 1'b0; right_in = 1'b0; bus.cmd_ready = 1'b1;
    tick(1);
    expect_st("lr_run", pk(1'b0, 2'b11, 4'd0, 1'b0, S_RUN));
    reset = 1'b1;
    tick(1);
    expect_st("lr_reset", pk(1'b0, 2'b00, 4'd0, 1'b0, S_IDLE));
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
